// File: rtl/conv_mac_sequencer.sv
// ---------------------------------------------------------------------------
// conv_mac_sequencer
//
// Purpose:
//   ALU-control decoder with an attached multi-cycle convolution MAC
//   sequencer. A "conv" instruction (ALUOp=10, funct3=001) stalls the
//   pipeline while TAPS signed pixel*weight products are accumulated, one
//   per cycle. The result is then presented with a single-cycle valid pulse.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   asynchronous, active-low reset
//   issue_valid   in   decode-stage instruction valid
//   ALUOp         in   [1:0] main-decoder ALU class
//   funct3        in   [2:0] instruction funct3
//   funct7        in   [6:0] instruction funct7 (bit 0 selects accumulate mode)
//   op            in   [6:0] instruction opcode
//   flush         in   pipeline flush, aborts an in-flight conv
//   pixel_in      in   [DATA_W-1:0] signed pixel for the current tap
//   weight_in     in   [DATA_W-1:0] signed weight for the current tap
//   ALUControl    out  [2:0] combinational ALU control
//   stall         out  holds the pipeline while a conv runs
//   tap_idx       out  [TAP_W-1:0] tap index for operand fetch
//   mac_en        out  high when pixel_in/weight_in are consumed
//   result        out  [ACC_W-1:0] signed accumulator value
//   result_valid  out  one-cycle pulse when a conv completes
// ---------------------------------------------------------------------------
module conv_mac_sequencer #(
   parameter  int DATA_W = 16,
   parameter  int TAPS   = 9,
   localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1,
   localparam int ACC_W  = 2 * DATA_W + $clog2(TAPS) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   input  logic [1:0]               ALUOp,
   input  logic [2:0]               funct3,
   input  logic [6:0]               funct7,
   input  logic [6:0]               op,
   input  logic                     flush,
   input  logic signed [DATA_W-1:0] pixel_in,
   input  logic signed [DATA_W-1:0] weight_in,
   output logic [2:0]               ALUControl,
   output logic                     stall,
   output logic [TAP_W-1:0]         tap_idx,
   output logic                     mac_en,
   output logic signed [ACC_W-1:0]  result,
   output logic                     result_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_nextState;
   logic [TAP_W-1:0]           r_tapCnt;
   logic signed [ACC_W-1:0]    r_acc;
   logic                       w_convIssue;
   logic                       w_accMode;
   logic                       w_start;
   logic                       w_lastTap;
   logic signed [2*DATA_W-1:0] w_prod;
   logic                       w_unusedBits;

   // Only op[5], funct7[5] and funct7[0] carry meaning for this block.
   assign w_unusedBits = ^{op[6], op[4:0], funct7[6], funct7[4:1]};

   assign w_convIssue = issue_valid && (ALUOp == 2'b10) && (funct3 == 3'b001);
   assign w_accMode   = funct7[0];
   // Flush wins over a conv issue arriving in the same cycle, so a conv
   // only starts when no flush is present.
   assign w_start     = (r_state == IDLE) && w_convIssue && !flush;
   assign w_lastTap   = (r_tapCnt == TAP_W'(TAPS - 1));
   assign w_prod      = pixel_in * weight_in;

   // ALU control decode. This is purely combinational and works regardless
   // of the sequencer state.
   always_comb begin
      ALUControl = 3'b000;
      case (ALUOp)
         2'b00: ALUControl = 3'b000;
         2'b01: ALUControl = 3'b001;
         2'b11: ALUControl = 3'b100;
         default: begin
            case (funct3)
               3'b000:  ALUControl = ({op[5], funct7[5]} == 2'b11) ? 3'b001 : 3'b000;
               3'b001:  ALUControl = 3'b111;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
      endcase
   end

   // State register. The reset is asynchronous so that the sequencer drops
   // out of RUN immediately, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Issues seen in RUN or DONE are ignored. A flush
   // sends the sequencer straight back to IDLE from either busy state.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_start) w_nextState = RUN;
         end
         RUN: begin
            if (flush)          w_nextState = IDLE;
            else if (w_lastTap) w_nextState = DONE;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Tap counter and accumulator. On a start the counter is cleared and the
   // accumulator is cleared unless accumulate mode is requested. Every RUN
   // cycle adds one sign-extended full-precision product. The sum wraps
   // naturally at ACC_W bits. A flush leaves the partial sum in place.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tapCnt <= '0;
         r_acc    <= '0;
      end else if (w_start) begin
         r_tapCnt <= '0;
         if (!w_accMode) r_acc <= '0;
      end else if (r_state == RUN) begin
         r_tapCnt <= r_tapCnt + TAP_W'(1);
         r_acc    <= r_acc + ACC_W'(w_prod);
      end
   end

   // Handshake outputs. The stall drops in DONE so that the next instruction
   // advances in the same cycle that the result is valid.
   assign mac_en       = (r_state == RUN);
   assign tap_idx      = (r_state == RUN) ? r_tapCnt : '0;
   assign stall        = w_start || (r_state == RUN);
   assign result_valid = (r_state == DONE) && !flush;
   assign result       = r_acc;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_mac_sequencer
//
// This testbench drives two instances of conv_mac_sequencer:
//   - one with TAPS=9
//   - one with TAPS=1
//
// Expected values come from a behavioural model kept in this file.
// The conv result is a plain running integer sum of products, masked to the
// accumulator width. Timing expectations follow the issue -> TAPS busy
// cycles -> one valid-cycle contract.
// ---------------------------------------------------------------------------
module tb_conv_mac_sequencer;

   localparam int DW     = 16;
   localparam int TAPS9  = 9;
   localparam int ACC9   = 2 * DW + 4 + 1;
   localparam int TAPW9  = 4;
   localparam int ACC1   = 2 * DW + 0 + 1;

   logic clk;
   logic rst;

   // Inputs and outputs of the TAPS=9 instance.
   logic                 issueValid;
   logic [1:0]           aluOp;
   logic [2:0]           funct3;
   logic [6:0]           funct7;
   logic [6:0]           op;
   logic                 flush;
   logic signed [DW-1:0] pixel;
   logic signed [DW-1:0] weight;
   logic [2:0]           aluCtl;
   logic                 stall;
   logic [TAPW9-1:0]     tapIdx;
   logic                 macEn;
   logic [ACC9-1:0]      result;
   logic                 resultValid;

   // Inputs and outputs of the TAPS=1 instance.
   logic                 issueValid1;
   logic [6:0]           funct7One;
   logic signed [DW-1:0] pixel1;
   logic signed [DW-1:0] weight1;
   logic [2:0]           aluCtl1;
   logic                 stall1;
   logic [0:0]           tapIdx1;
   logic                 macEn1;
   logic [ACC1-1:0]      result1;
   logic                 resultValid1;

   int     checkCount;
   int     errCount;
   longint modelAcc;
   longint mask9;

   conv_mac_sequencer #(.DATA_W(DW), .TAPS(TAPS9)) dut9 (
      .clk(clk), .rst(rst), .issue_valid(issueValid), .ALUOp(aluOp),
      .funct3(funct3), .funct7(funct7), .op(op), .flush(flush),
      .pixel_in(pixel), .weight_in(weight), .ALUControl(aluCtl),
      .stall(stall), .tap_idx(tapIdx), .mac_en(macEn), .result(result),
      .result_valid(resultValid)
   );

   conv_mac_sequencer #(.DATA_W(DW), .TAPS(1)) dut1 (
      .clk(clk), .rst(rst), .issue_valid(issueValid1), .ALUOp(2'b10),
      .funct3(3'b001), .funct7(funct7One), .op(7'b0110011), .flush(1'b0),
      .pixel_in(pixel1), .weight_in(weight1), .ALUControl(aluCtl1),
      .stall(stall1), .tap_idx(tapIdx1), .mac_en(macEn1), .result(result1),
      .result_valid(resultValid1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts every comparison and reports any that disagree.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // ALU control table, written straight from the decode rules.
   function automatic logic [2:0] expAluCtl(input logic [1:0] a,
                                            input logic [2:0] f3,
                                            input logic [1:0] b);
      if (a == 2'b00) return 3'b000;
      if (a == 2'b01) return 3'b001;
      if (a == 2'b11) return 3'b100;
      if (f3 == 3'b001) return 3'b111;
      if (f3 == 3'b000) return (b == 2'b11) ? 3'b001 : 3'b000;
      if (f3 == 3'b010) return 3'b101;
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b111) return 3'b010;
      return 3'b000;
   endfunction

   task automatic setConv(input logic accMode);
      issueValid = 1'b1;
      aluOp      = 2'b10;
      funct3     = 3'b001;
      funct7     = {6'b0, accMode};
      op         = 7'b0110011;
   endtask

   // Runs one full conv on the TAPS=9 instance and checks every cycle.
   // If pokeIssue is set, the conv instruction is re-presented mid-run;
   // the sequencer must ignore it.
   task automatic applyStimulus(input logic accMode, input bit useConst,
                                input int pC, input int wC, input bit pokeIssue);
      logic signed [DW-1:0] px;
      logic signed [DW-1:0] wt;
      @(posedge clk); #1;
      setConv(accMode);
      @(negedge clk);
      checkOutput("issueStall", stall, 1);
      checkOutput("issueMacEn", macEn, 0);
      checkOutput("issueTapIdx", tapIdx, 0);
      if (!accMode) modelAcc = 0;
      for (int k = 0; k < TAPS9; k++) begin
         @(posedge clk); #1;
         issueValid = pokeIssue && (k == 3);
         px = useConst ? DW'(pC) : DW'($urandom);
         wt = useConst ? DW'(wC) : DW'($urandom);
         pixel  = px;
         weight = wt;
         @(negedge clk);
         checkOutput("runMacEn", macEn, 1);
         checkOutput("runTapIdx", tapIdx, 64'(k));
         checkOutput("runStall", stall, 1);
         checkOutput("runValid", resultValid, 0);
         modelAcc = modelAcc + longint'(px) * longint'(wt);
      end
      @(posedge clk); #1;
      issueValid = 1'b0;
      @(negedge clk);
      checkOutput("doneValid", resultValid, 1);
      checkOutput("doneStall", stall, 0);
      checkOutput("doneMacEn", macEn, 0);
      checkOutput("doneResult", result, modelAcc & mask9);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("idleValid", resultValid, 0);
      checkOutput("idleResult", result, modelAcc & mask9);
   endtask

   // Expected TAPS=1 timeline for a conv instruction held on issue, per
   // cycle after the first issue. Columns are mac_en, stall, result_valid.
   logic [2:0] oneTapExp [1:5];

   initial begin
      checkCount  = 0;
      errCount    = 0;
      modelAcc    = 0;
      mask9       = (longint'(1) <<< ACC9) - 1;
      rst         = 1'b0;
      issueValid  = 1'b0;
      aluOp       = 2'b00;
      funct3      = 3'b000;
      funct7      = 7'b0;
      op          = 7'b0;
      flush       = 1'b0;
      pixel       = '0;
      weight      = '0;
      issueValid1 = 1'b0;
      funct7One   = 7'b0;
      pixel1      = '0;
      weight1     = '0;

      // Reset state.
      #3;
      checkOutput("rstStall", stall, 0);
      checkOutput("rstMacEn", macEn, 0);
      checkOutput("rstResult", result, 0);
      checkOutput("rstValid", resultValid, 0);
      checkOutput("rstTapIdx", tapIdx, 0);
      checkOutput("rstResult1", result1, 0);
      #20 rst = 1'b1;

      // Decode sweep over every combination. Issue is held low so the
      // sequencer stays idle throughout.
      for (int a = 0; a < 4; a++) begin
         for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 4; b++) begin
               aluOp  = 2'(a);
               funct3 = 3'(f);
               op     = b[1] ? 7'b0110011 : 7'b0010011;
               funct7 = b[0] ? 7'b0100000 : 7'b0000000;
               #1;
               checkOutput("decode", aluCtl, expAluCtl(2'(a), 3'(f), 2'(b)));
            end
         end
      end

      // Fixed-pattern convs: a fresh conv, then an accumulating follow-up.
      applyStimulus(1'b0, 1'b1, 3, -2, 1'b0);
      checkOutput("fixedConvA", result, longint'(-54) & mask9);
      applyStimulus(1'b1, 1'b1, 1, 1, 1'b0);
      checkOutput("fixedConvB", result, longint'(-45) & mask9);

      // Non-conv issues while idle must not stall or disturb the accumulator.
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         issueValid = 1'b1;
         aluOp      = 2'($urandom);
         funct3     = 3'($urandom);
         funct7     = 7'($urandom) | 7'b0000001;
         op         = 7'($urandom);
         if (aluOp == 2'b10 && funct3 == 3'b001) funct3 = 3'b000;
         @(negedge clk);
         checkOutput("nonConvStall", stall, 0);
         checkOutput("nonConvMacEn", macEn, 0);
         checkOutput("nonConvResult", result, modelAcc & mask9);
      end
      issueValid = 1'b0;
      applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);

      // Randomized convs, one of which sees a re-issue mid-run.
      for (int r = 0; r < 4; r++) begin
         applyStimulus(1'($urandom), 1'b0, 0, 0, (r == 1));
      end

      // A flush on the fourth RUN cycle aborts the conv.
      @(posedge clk); #1;
      setConv(1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         issueValid = 1'b0;
         pixel  = DW'($urandom);
         weight = DW'($urandom);
         flush  = (k == 3);
         @(negedge clk);
         checkOutput("flushRunMacEn", macEn, 1);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checkOutput("flushStall", stall, 0);
      checkOutput("flushMacEn", macEn, 0);
      checkOutput("flushTapIdx", tapIdx, 0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checkOutput("flushNoValid", resultValid, 0);
      end

      // Reset asserted on the fifth RUN cycle takes effect immediately.
      @(posedge clk); #1;
      setConv(1'b0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         issueValid = 1'b0;
      end
      #2 rst = 1'b0;
      #1;
      checkOutput("midRstStall", stall, 0);
      checkOutput("midRstMacEn", macEn, 0);
      checkOutput("midRstTapIdx", tapIdx, 0);
      checkOutput("midRstValid", resultValid, 0);
      checkOutput("midRstResult", result, 0);
      @(posedge clk); #3;
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checkOutput("postRstNoValid", resultValid, 0);
      end
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);

      // TAPS=1: a conv instruction held on issue is accepted at T and then
      // again only after DONE, at T+3.
      oneTapExp[1] = 3'b110;
      oneTapExp[2] = 3'b001;
      oneTapExp[3] = 3'b010;
      oneTapExp[4] = 3'b110;
      oneTapExp[5] = 3'b001;
      @(posedge clk); #1;
      issueValid1 = 1'b1;
      funct7One   = 7'b0;
      pixel1      = -16'sd32768;
      weight1     = -16'sd32768;
      @(negedge clk);
      checkOutput("oneStallT", stall1, 1);
      checkOutput("oneMacEnT", macEn1, 0);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c == 5) issueValid1 = 1'b0;
         @(negedge clk);
         checkOutput("oneMacEn", macEn1, oneTapExp[c][2]);
         checkOutput("oneStall", stall1, oneTapExp[c][1]);
         checkOutput("oneValid", resultValid1, oneTapExp[c][0]);
         checkOutput("oneTapIdx", tapIdx1, 0);
         if (c == 2 || c == 5) begin
            checkOutput("oneResult", result1,
                        longint'(-32768) * longint'(-32768));
         end
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/conv_mac_sequencer.md
CONV_MAC_SEQUENCER -- requirements
Module: conv_mac_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: signed pixel and weight operand width.
REQ-002 Parameter TAPS, default 9: MAC taps per conv instruction (K*K); legal range 1..256.
REQ-003 Localparam TAP_W = max(1, clog2(TAPS)); localparam ACC_W = 2*DATA_W + clog2(TAPS) + 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 issue_valid  in  1  decode-stage instruction valid.
REQ-007 ALUOp  in  2  main-decoder ALU class.
REQ-008 funct3  in  3  instruction funct3.
REQ-009 funct7  in  7  instruction funct7.
REQ-010 op  in  7  instruction opcode.
REQ-011 flush  in  1  pipeline flush; aborts an in-flight conv.
REQ-012 pixel_in  in  DATA_W  signed pixel for current tap.
REQ-013 weight_in  in  DATA_W  signed weight for current tap.
REQ-014 ALUControl  out  3  combinational ALU control.
REQ-015 stall  out  1  holds the pipeline while a conv runs.
REQ-016 tap_idx  out  TAP_W  tap index for operand fetch.
REQ-017 mac_en  out  1  high in cycles where pixel_in/weight_in are consumed.
REQ-018 result  out  ACC_W  signed accumulator value.
REQ-019 result_valid  out  1  one-cycle pulse when conv completes.

Function
REQ-020 ALUControl: ALUOp 00->000; 01->001; 11->100; 10 with funct3 001->111 (conv), 000 & {op[5],funct7[5]}==11->001, 000 otherwise->000, 010->101, 110->011, 111->010, other funct3->000.
REQ-021 conv_issue = issue_valid & ALUOp==10 & funct3==001; acc_mode = funct7[0] at issue (1: keep accumulator, 0: clear).
REQ-022 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-023 IDLE: on conv_issue -> RUN; tap counter <= 0; accumulator <= 0 unless acc_mode=1.
REQ-024 RUN: mac_en=1; tap_idx = tap counter; accumulator += sign-extended(pixel_in * weight_in) full-precision signed product; counter increments.
REQ-025 RUN at tap counter == TAPS-1 -> DONE; exactly TAPS RUN cycles per conv.
REQ-026 DONE: result_valid=1 for exactly one cycle; -> IDLE next cycle.
REQ-027 result always shows the accumulator register; holds value in IDLE until next non-accumulate issue.
REQ-028 Latency: issue at cycle T -> RUN T+1..T+TAPS -> result_valid at T+TAPS+1.
REQ-029 stall = conv_issue in IDLE, or state RUN; deasserted in DONE so the next instruction advances with result valid.
REQ-030 conv_issue while in RUN or DONE is ignored (no restart, no counter change).
REQ-031 Non-conv issues never change FSM, counter or accumulator.
REQ-032 Accumulator wraps modulo 2^ACC_W in acc_mode chains; no saturation.
REQ-033 flush in RUN or DONE: next state IDLE, result_valid stays 0, accumulator keeps partial value; flush has priority over conv_issue in the same cycle.
REQ-034 mac_en=0 and tap_idx=0 outside RUN.

Reset
REQ-035 rst low asynchronously forces IDLE, counter 0, accumulator 0, stall 0, mac_en 0, result_valid 0, result 0, tap_idx 0, regardless of clk.
REQ-036 Reset mid-RUN discards the conv; no result_valid after release.

Verification
REQ-037 Decode sweep: all ALUOp/funct3/{op[5],funct7[5]} combinations -> ALUControl per REQ-020 (e.g. ALUOp 10, funct3 000, op 0110011, funct7 0100000 -> 001).
REQ-038 TAPS=9, conv issue funct7[0]=0, pixel_in=3, weight_in=-2 every tap -> tap_idx 0..8, stall high 10 cycles, result_valid at T+10, result=-54.
REQ-039 Follow-up conv with funct7[0]=1, pixel_in=1, weight_in=1 -> result=-45.
REQ-040 Flush at 4th RUN cycle -> IDLE next cycle, no result_valid, stall low.
REQ-041 rst low at 5th RUN cycle -> all outputs 0 immediately; next conv after release gives correct result.
REQ-042 TAPS=1, pixel_in=-32768, weight_in=-32768 -> result=1073741824 at T+2; back-to-back issue accepted only after DONE.
